// File: rtl/tt_um_seg7_rx_pkg.sv
// tt_um_seg7_rx_pkg: FSM states, hex segment table (gfedcba, bit0 = a) and blank pattern
package tt_um_seg7_rx_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCEPT = 2'd2
  } state_t;
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] BLANK_PAT = 7'h00;
endpackage

// File: rtl/seg7_lookup.sv
// seg7_lookup: combinational segment pattern decoder
//   pat_i    : 7-bit segment pattern (gfedcba)
//   nibble_o : hex value when hit_o is high, else 0
//   hit_o    : pattern is one of the 16 hex glyphs
//   blank_o  : pattern is all segments off
module seg7_lookup
  import tt_um_seg7_rx_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nibble_o,
  output logic       hit_o,
  output logic       blank_o
);
  always_comb begin
    nibble_o = '0;
    hit_o = 1'b0;
    for (int i = 0; i < 16; i++)
      if (pat_i == SEG_HEX[i]) begin
        nibble_o = 4'(i);
        hit_o = 1'b1;
      end
  end
  assign blank_o = pat_i == BLANK_PAT;
endmodule

// File: rtl/tt_um_seg7_rx.sv
// tt_um_seg7_rx: debounced 7-segment display receiver, decodes the shown hex digit
//   clk, rst_n : clock, asynchronous active-low reset
//   ena, uio_in, ui_in[7] : ignored
//   ui_in[6:0] : segments a..g, active high
//   uo_out     : [3:0] nibble, [4] valid pulse, [5] error, [6] blank, [7] settling
//   uio_out    : accepted-digit count (only with SEG7_RX_COUNT_EN, else 0)
//   uio_oe     : 8'hFF with SEG7_RX_COUNT_EN, else 8'h00
// Optional feature macro: SEG7_RX_COUNT_EN
module tt_um_seg7_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import tt_um_seg7_rx_pkg::*;
  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);
  logic [6:0] s1_q, s2_q, cand_q, last_q;
  logic [3:0] cnt_q, nibble_q, look_nib;
  logic       settle_q, valid_q, error_q, blank_q, look_hit, look_blank;
  state_t     state_q;
  logic       unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7]};
  seg7_lookup u_lookup (
    .pat_i   (cand_q),
    .nibble_o(look_nib),
    .hit_o   (look_hit),
    .blank_o (look_blank)
  );
  // Decision is taken on the SETTLE->ACCEPT edge so valid lands in the ACCEPT cycle;
  // ACCEPT itself is a one-cycle dead time before returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      settle_q <= 1'b0;
      nibble_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      blank_q  <= 1'b1;
    end else begin
      s1_q    <= ui_in[6:0];
      s2_q    <= s1_q;
      valid_q <= 1'b0;
      case (state_q)
        IDLE:
          if (s2_q != cand_q) begin
            cand_q   <= s2_q;
            cnt_q    <= '0;
            state_q  <= SETTLE;
            settle_q <= 1'b1;
          end
        SETTLE:
          if (s2_q != cand_q) begin
            cand_q <= s2_q;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= ACCEPT;
            settle_q <= 1'b0;
            // Re-accepting the last pattern (glitch-and-return) leaves outputs untouched.
            if (cand_q != last_q) begin
              last_q  <= cand_q;
              error_q <= !look_hit && !look_blank;
              blank_q <= look_blank;
              if (look_hit) begin
                nibble_q <= look_nib;
                valid_q  <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        ACCEPT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign uo_out = {settle_q, blank_q, error_q, valid_q, nibble_q};
`ifdef SEG7_RX_COUNT_EN
  logic [7:0] count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_q + {7'd0, valid_q};
  end
  assign uio_out = count_q;
  assign uio_oe  = 8'hFF;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif
endmodule

// File: tb/tb_tt_um_seg7_rx.sv
// tb_tt_um_seg7_rx: table, directed and randomized checks of the 7-segment receiver
module tb_tt_um_seg7_rx;
  localparam int ST = 4;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef struct {
    logic [7:0] ui;
    logic [7:0] uo;
    int         dp;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         got_p;
  int         exp_p;
  logic [6:0] m_last;
  logic [3:0] m_nib;
  logic       m_err, m_blank;
  vec_t       tbl [13];
  always #5 clk = ~clk;
  tt_um_seg7_rx #(.STABLE_CYCLES(ST)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );
  always @(posedge clk or negedge rst_n)
    if (!rst_n) got_p <= 0;
    else if (uo_out[4]) got_p <= got_p + 1;
  function automatic logic [7:0] exp_uio();
`ifdef SEG7_RX_COUNT_EN
    return 8'(exp_p);
`else
    return 8'h00;
`endif
  endfunction
  function automatic logic [7:0] exp_oe();
`ifdef SEG7_RX_COUNT_EN
    return 8'hFF;
`else
    return 8'h00;
`endif
  endfunction
  function automatic logic [7:0] exp_uo();
    return {1'b0, m_blank, m_err, 1'b0, m_nib};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic model_clear();
    exp_p = 0;
    m_last = 7'h00;
    m_nib = 4'h0;
    m_err = 1'b0;
    m_blank = 1'b1;
  endtask
  // A pattern that stays long enough is taken; only a change of pattern matters.
  task automatic model_acc(input logic [6:0] p);
    if (p != m_last) begin
      m_last = p;
      m_blank = p == 7'h00;
      m_err = !m_blank;
      for (int i = 0; i < 16; i++)
        if (HEX[i] == p) begin
          m_nib = 4'(i);
          m_err = 1'b0;
          exp_p++;
        end
    end
  endtask
  task automatic chk_state(input string nm);
    chk({nm, " uo_out"}, uo_out, exp_uo());
    chk({nm, " pulses"}, got_p, exp_p);
    chk({nm, " uio_out"}, uio_out, exp_uio());
    chk({nm, " uio_oe"}, uio_oe, exp_oe());
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset uo_out", uo_out, 8'h40);
    chk("reset uio_out", uio_out, 8'h00);
    chk("reset uio_oe", uio_oe, exp_oe());
    rst_n = 1'b1;
    model_clear();
  endtask
  task automatic long_seg(input logic [7:0] v, input int n);
    ui_in = v;
    repeat (n) @(negedge clk);
    model_acc(v[6:0]);
  endtask
  initial begin
    logic [7:0] v;
    logic [6:0] prev;
    int p0;
    tbl = '{
      '{8'h5B, 8'h02, 1}, '{8'h06, 8'h01, 1}, '{8'h49, 8'h21, 0}, '{8'h3F, 8'h00, 1},
      '{8'h00, 8'h40, 0}, '{8'h71, 8'h0F, 1}, '{8'h63, 8'h2F, 0}, '{8'h79, 8'h0E, 1},
      '{8'hF9, 8'h0E, 0}, '{8'h7C, 8'h0B, 1}, '{8'h39, 8'h0C, 1}, '{8'h00, 8'h4C, 0},
      '{8'h06, 8'h01, 1}
    };
    model_clear();
    do_reset();
    // Latency from capture edge 1: settling after edge 3, valid after edge ST+3.
    ui_in = 8'h5B;
    repeat (2) @(negedge clk);
    chk("lat idle", uo_out, 8'h40);
    @(negedge clk);
    chk("lat settling", uo_out, 8'hC0);
    repeat (ST - 1) @(negedge clk);
    chk("lat pre-valid", uo_out, 8'hC0);
    @(negedge clk);
    chk("lat valid", uo_out, 8'h12);
    @(negedge clk);
    chk("lat after", uo_out, 8'h02);
    model_acc(7'h5B);
    chk_state("lat");
    // Table of held patterns starting from reset.
    do_reset();
    foreach (tbl[i]) begin
      p0 = got_p;
      long_seg(tbl[i].ui, 12);
      chk($sformatf("tbl%0d uo_out", i), uo_out, tbl[i].uo);
      chk($sformatf("tbl%0d pulses", i), got_p - p0, tbl[i].dp);
      chk_state($sformatf("tbl%0d model", i));
    end
    // 5B held 2 cycles then 06: only 06 is reported.
    do_reset();
    ui_in = 8'h5B;
    repeat (2) @(negedge clk);
    ui_in = 8'h06;
    repeat (ST + 2) @(negedge clk);
    chk("switch pre-valid", uo_out, 8'hC0);
    @(negedge clk);
    chk("switch valid", uo_out, 8'h11);
    repeat (4) @(negedge clk);
    model_acc(7'h06);
    chk_state("switch");
    // Glitch to 7F for 2 cycles and back: settling only.
    long_seg(8'h5B, 12);
    chk_state("pre-glitch");
    ui_in = 8'h7F;
    repeat (2) @(negedge clk);
    ui_in = 8'h5B;
    @(negedge clk);
    chk("glitch settling", uo_out, 8'h82);
    repeat (12) @(negedge clk);
    chk_state("glitch");
    // Boundary: ST cycles is too short, ST+1 is accepted.
    ui_in = 8'h06;
    repeat (ST) @(negedge clk);
    long_seg(8'h5B, 12);
    chk_state("hold ST");
    ui_in = 8'h06;
    repeat (ST + 1) @(negedge clk);
    ui_in = 8'h5B;
    repeat (2) @(negedge clk);
    chk("hold ST+1 valid", uo_out, 8'h11);
    model_acc(7'h06);
    long_seg(8'h5B, 10);
    chk_state("hold ST+1");
    // Reset in the second SETTLE cycle aborts; the held input is re-acquired.
    do_reset();
    ui_in = 8'h5B;
    repeat (4) @(negedge clk);
    chk("abort settling", uo_out[7], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort uo_out", uo_out, 8'h40);
    chk("abort uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (ST + 2) @(negedge clk);
    chk("reacq pre-valid", uo_out, 8'hC0);
    @(negedge clk);
    chk("reacq valid", uo_out, 8'h12);
    repeat (2) @(negedge clk);
    model_acc(7'h5B);
    chk_state("reacq");
    // Random segments: short ones never accepted, long ones always decided.
    prev = ui_in[6:0];
    for (int s = 0; s < 80; s++) begin
      do begin
        case ($urandom_range(0, 3))
          0, 1: v = {1'b0, HEX[$urandom_range(0, 15)]};
          2: v = 8'h00;
          default: v = 8'($urandom);
        endcase
      end while (v[6:0] == prev);
      v[7] = 1'($urandom);
      prev = v[6:0];
      if (s != 79 && $urandom_range(0, 2) == 0) begin
        ui_in = v;
        repeat ($urandom_range(1, ST - 1)) @(negedge clk);
      end else begin
        long_seg(v, $urandom_range(8, 14));
        chk_state($sformatf("rand%0d", s));
      end
    end
    // 256 accepted digits wrap the count back to 0.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      long_seg(k[0] ? 8'h5B : 8'h06, 8);
      if (k == 254) chk_state("wrap 255");
    end
    repeat (2) @(negedge clk);
    chk_state("wrap 256");
    chk("wrap uio_out", uio_out, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tt_um_seg7_rx.md
TT_UM_SEG7_RX -- requirements
Module: tt_um_seg7_rx

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 1..15: consecutive cycles a synchronized segment pattern must stay unchanged before it is accepted.
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port ena, input, 1: tile enable, ignored.
REQ-005 SHALL have port ui_in, input, 8: [6:0] are segments a..g, active high, bit0 = a; [7] (dp) is ignored.
REQ-006 SHALL have port uio_in, input, 8: unused.
REQ-007 SHALL have port uo_out, output, 8: [3:0] nibble, [4] valid, [5] error, [6] blank, [7] settling.
REQ-008 SHALL have port uio_out, output, 8: accepted-digit count.
REQ-009 SHALL have port uio_oe, output, 8: 8'hFF when SEG7_RX_COUNT_EN is defined, else 8'h00.

Function
REQ-010 SHALL pass ui_in[6:0] through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-011 SHALL implement FSM IDLE, SETTLE, ACCEPT.
REQ-012 IDLE, s2 != cand: SHALL load cand <= s2, clear cnt, go to SETTLE.
REQ-013 SETTLE, s2 == cand: SHALL increment cnt; when cnt == STABLE_CYCLES-1, SHALL go to ACCEPT on the same edge.
REQ-014 SETTLE, s2 != cand: SHALL reload cand, clear cnt, stay in SETTLE; acceptance restarts.
REQ-015 ACCEPT SHALL last exactly one cycle, then return to IDLE.
REQ-016 Latency: with edge 1 as the ui_in capture edge and no further change, valid SHALL be high in the cycle after edge STABLE_CYCLES+3 (edge 7 for default).
REQ-017 Accepted pattern equal to last-accepted register SHALL produce no output change (glitch-and-return is invisible).
REQ-018 Accepted pattern in the hex table (gfedcba) SHALL update nibble, pulse valid for 1 cycle, clear error and blank. Table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-019 Accepted 0x00 SHALL set blank, clear error, hold nibble, and pulse no valid.
REQ-020 Any other accepted pattern SHALL set error, clear blank, hold nibble, and pulse no valid.
REQ-021 error and blank SHALL hold until the next accepted, differing pattern.
REQ-022 settling (uo_out[7]) SHALL be high exactly while the FSM is in SETTLE.
REQ-023 The count SHALL increment once per valid pulse, 8 bits, wrapping 255 -> 0.
REQ-024 All outputs SHALL be registered; no combinational path from ui_in to any output.

Reset
REQ-025 While rst_n = 0, SHALL force s1, s2, cand, the last-accepted register, cnt and count to 0; FSM IDLE; uo_out = 8'h40 (blank = 1); uio_out = 0.
REQ-026 Reset asserted mid-SETTLE or in ACCEPT SHALL abort without a valid pulse; after release the current input is re-acquired from IDLE.

Configuration
REQ-027 With SEG7_RX_COUNT_EN defined, the count register SHALL exist, drive uio_out, and uio_oe = 8'hFF.
REQ-028 Without SEG7_RX_COUNT_EN, there SHALL be no count register, uio_out = 0 and uio_oe = 0; uo_out behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the 16-entry segment table constants, and the blank pattern constant.
REQ-030 The pattern-to-nibble lookup (7-bit pattern in; nibble, hit and blank out; purely combinational) SHALL be sub-module seg7_lookup.

Verification
REQ-031 After reset, apply ui_in = 8'h5B and hold -> uo_out = 8'h12 in the cycle after edge 7, then 8'h02; uio_out = 1.
REQ-032 Hold 8'h5B for 2 cycles, then apply 8'h06 -> no pulse for 5B; one pulse with nibble 1 at edge 7 counted from the 06 capture.
REQ-033 After accepting 5B, glitch to 7F for 2 cycles and return to 5B -> settling rises, no valid pulse, count unchanged.
REQ-034 Apply 8'h49 -> error = 1, nibble held, no pulse; then 3F -> error = 0, nibble 0, one pulse.
REQ-035 Drive 256 alternating valid digits -> uio_out wraps to 0; without SEG7_RX_COUNT_EN, uio_out = uio_oe = 0 throughout.
REQ-036 Assert rst_n = 0 in SETTLE cycle 2 -> no valid pulse, uo_out = 8'h40; after release the held pattern is accepted after full latency.
